// File: rtl/fetch_pkg.sv
// Shared pipeline definitions for the fetch stage: exception codes, FSM states, reset vector.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0400;
  localparam logic [7:0]  EXC_NONE           = 8'h00;
  localparam logic [7:0]  EXC_FETCH_TLB      = 8'h82;
  localparam logic [7:0]  EXC_FETCH_MISALIGN = 8'h84;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  // Response presented to decode alongside the memory read data.
  typedef struct packed {
    logic [31:0] pc;
    logic        bubble;
    logic [7:0]  exc;
    logic        pred_taken;
  } fetch_rsp_t;

  function automatic logic is_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup, update written at the clock edge.
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lookup_pc,
  output logic        hit,
  output logic [31:0] target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [31:0]        targets [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             unused_lsb;

  assign lk_idx     = lookup_pc[IDX_W+1:2];
  assign lk_tag     = lookup_pc[31:IDX_W+2];
  assign up_idx     = upd_pc[IDX_W+1:2];
  assign up_tag     = upd_pc[31:IDX_W+2];
  assign unused_lsb = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign hit    = valid[lk_idx] && (tags[lk_idx] == lk_tag);
  assign target = targets[lk_idx];

  // A not-taken resolution only evicts the entry that actually predicted it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (upd_en) begin
      if (upd_taken) begin
        valid[up_idx] <= 1'b1;
      end else if (tags[up_idx] == up_tag) begin
        valid[up_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (upd_en && upd_taken) begin
      tags[up_idx]    <= up_tag;
      targets[up_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one read per cycle, registers the aligned response.
// Optional branch target buffer enabled by defining FETCH_BTB_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        halt,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        tlb_miss,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic [31:0] pc_out,
  output logic        bubble_out,
  output logic [7:0]  exc_out,
  output logic        pred_taken_out,
  input  logic        btb_upd,
  input  logic [31:0] btb_upd_pc,
  input  logic [31:0] btb_upd_target,
  input  logic        btb_upd_taken
);

  fetch_state_t state;
  fetch_rsp_t   rsp;
  logic [31:0]  fetch_pc;
  logic [31:0]  next_pc;
  logic         active;
  logic         in_run;
  logic         fault_tlb;
  logic         fault_mis;
  logic         btb_hit;
  logic [31:0]  btb_target;

  assign active    = clk_en && !halt;
  assign in_run    = (state == ST_RUN);
  assign fault_tlb = in_run && tlb_miss;
  assign fault_mis = in_run && is_misaligned(fetch_pc);
  assign next_pc   = btb_hit ? btb_target : fetch_pc + 32'd4;

`ifdef FETCH_BTB_EN
  fetch_btb #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_pc  (fetch_pc),
    .hit        (btb_hit),
    .target     (btb_target),
    .upd_en     (active && btb_upd),
    .upd_pc     (btb_upd_pc),
    .upd_target (btb_upd_target),
    .upd_taken  (btb_upd_taken)
  );
`else
  localparam int unused_btb_entries = BTB_ENTRIES;
  logic unused_btb;
  assign unused_btb = ^{btb_upd, btb_upd_pc, btb_upd_target, btb_upd_taken};
  assign btb_hit    = 1'b0;
  assign btb_target = '0;
`endif

  // Only a clean RUN cycle reads; BOOT shows RESET_PC without reading it so the word is fetched once.
  assign mem_re = active && in_run && !redirect && !tlb_miss && !is_misaligned(fetch_pc) && !stall;
  assign mem_addr       = fetch_pc;
  assign pc_out         = rsp.pc;
  assign bubble_out     = rsp.bubble;
  assign exc_out        = rsp.exc;
  assign pred_taken_out = rsp.pred_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_BOOT;
      fetch_pc       <= RESET_PC;
      rsp.pc         <= '0;
      rsp.bubble     <= 1'b1;
      rsp.exc        <= EXC_NONE;
      rsp.pred_taken <= 1'b0;
    end else if (active) begin
      if (redirect) begin
        fetch_pc       <= redirect_pc;
        rsp.bubble     <= 1'b1;
        rsp.exc        <= EXC_NONE;
        rsp.pred_taken <= 1'b0;
        state          <= ST_RUN;
      end else if (fault_tlb) begin
        // The miss belongs to the word already presented, so its PC stays.
        rsp.bubble     <= 1'b0;
        rsp.exc        <= EXC_FETCH_TLB;
        rsp.pred_taken <= 1'b0;
        state          <= ST_HOLD;
      end else if (fault_mis) begin
        rsp.pc         <= fetch_pc;
        rsp.bubble     <= 1'b0;
        rsp.exc        <= EXC_FETCH_MISALIGN;
        rsp.pred_taken <= 1'b0;
        state          <= ST_HOLD;
      end else if (!stall) begin
        case (state)
          ST_BOOT: begin
            rsp.pc         <= fetch_pc;
            rsp.bubble     <= 1'b1;
            rsp.exc        <= EXC_NONE;
            rsp.pred_taken <= 1'b0;
            state          <= ST_RUN;
          end
          ST_RUN: begin
            rsp.pc         <= fetch_pc;
            rsp.bubble     <= 1'b0;
            rsp.exc        <= EXC_NONE;
            rsp.pred_taken <= btb_hit;
            fetch_pc       <= next_pc;
          end
          default: begin
            rsp.bubble     <= 1'b1;
            rsp.exc        <= EXC_NONE;
            rsp.pred_taken <= 1'b0;
            state          <= ST_HOLD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table, streaming scoreboard, reset and BTB sequences.
module tb_fetch_stage;

`ifdef FETCH_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        halt = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        tlb_miss = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] pc_out;
  logic        bubble_out;
  logic [7:0]  exc_out;
  logic        pred_taken_out;
  logic        btb_upd = 1'b0;
  logic [31:0] btb_upd_pc = '0;
  logic [31:0] btb_upd_target = '0;
  logic        btb_upd_taken = 1'b0;

  fetch_stage #(
    .RESET_PC    (32'h0000_0400),
    .BTB_ENTRIES (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_en         (clk_en),
    .halt           (halt),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .tlb_miss       (tlb_miss),
    .mem_addr       (mem_addr),
    .mem_re         (mem_re),
    .pc_out         (pc_out),
    .bubble_out     (bubble_out),
    .exc_out        (exc_out),
    .pred_taken_out (pred_taken_out),
    .btb_upd        (btb_upd),
    .btb_upd_pc     (btb_upd_pc),
    .btb_upd_target (btb_upd_target),
    .btb_upd_taken  (btb_upd_taken)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        tlb;
    logic        hlt;
    logic        cen;
    logic [31:0] e_addr;
    logic        e_re;
    logic [31:0] e_pc;
    logic        e_bub;
    logic [7:0]  e_exc;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] sb[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic vec_t v(input logic st, input logic rd, input logic [31:0] rpc,
                             input logic tlb, input logic hlt, input logic cen,
                             input logic [31:0] ea, input logic er, input logic [31:0] ep,
                             input logic eb, input logic [7:0] ee);
    return '{st: st, rd: rd, rpc: rpc, tlb: tlb, hlt: hlt, cen: cen,
             e_addr: ea, e_re: er, e_pc: ep, e_bub: eb, e_exc: ee};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc, input logic tlb);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    tlb_miss    = tlb;
    @(negedge clk);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ea, input logic er,
                         input logic [31:0] ep, input logic eb, input logic [7:0] ee,
                         input logic epred);
    chk({tag, " mem_addr"}, mem_addr, ea);
    chk({tag, " mem_re"}, {31'd0, mem_re}, {31'd0, er});
    chk({tag, " bubble"}, {31'd0, bubble_out}, {31'd0, eb});
    chk({tag, " exc"}, {24'd0, exc_out}, {24'd0, ee});
    chk({tag, " pred"}, {31'd0, pred_taken_out}, {31'd0, epred});
    if (!eb) chk({tag, " pc_out"}, pc_out, ep);
  endtask

  initial begin
    logic [31:0] exp_next;
    logic [31:0] last_pc;
    logic [31:0] got;
    logic        prev_issue;
    logic        have_last;
    logic        s;

    //        st rd rpc            tlb h  cen  addr          re pc            bub exc
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h0000_0400, 0, 32'h0,        1, 8'h00));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h0000_0400, 1, 32'h0,        1, 8'h00));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h0000_0404, 1, 32'h0000_0400, 0, 8'h00));
    tbl.push_back(v(1, 0, 32'h0,        0, 0, 1, 32'h0000_0408, 0, 32'h0000_0404, 0, 8'h00));
    tbl.push_back(v(1, 0, 32'h0,        0, 0, 1, 32'h0000_0408, 0, 32'h0000_0404, 0, 8'h00));
    tbl.push_back(v(1, 0, 32'h0,        0, 0, 1, 32'h0000_0408, 0, 32'h0000_0404, 0, 8'h00));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h0000_0408, 1, 32'h0000_0404, 0, 8'h00));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h0000_040C, 1, 32'h0000_0408, 0, 8'h00));
    tbl.push_back(v(1, 1, 32'h2000,     0, 0, 1, 32'h0000_0410, 0, 32'h0000_040C, 0, 8'h00));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h0000_2000, 1, 32'h0,        1, 8'h00));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h0000_2004, 1, 32'h0000_2000, 0, 8'h00));
    tbl.push_back(v(0, 1, 32'h2002,     0, 0, 1, 32'h0000_2008, 0, 32'h0000_2004, 0, 8'h00));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h0000_2002, 0, 32'h0,        1, 8'h00));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h0000_2002, 0, 32'h0000_2002, 0, 8'h84));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h0000_2002, 0, 32'h0,        1, 8'h00));
    tbl.push_back(v(0, 1, 32'h3000,     0, 0, 1, 32'h0000_2002, 0, 32'h0,        1, 8'h00));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h0000_3000, 1, 32'h0,        1, 8'h00));
    tbl.push_back(v(0, 1, 32'h04F8,     0, 0, 1, 32'h0000_3004, 0, 32'h0000_3000, 0, 8'h00));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h0000_04F8, 1, 32'h0,        1, 8'h00));
    tbl.push_back(v(0, 1, 32'h9000,     0, 1, 1, 32'h0000_04FC, 0, 32'h0000_04F8, 0, 8'h00));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 0, 32'h0000_04FC, 0, 32'h0000_04F8, 0, 8'h00));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h0000_04FC, 1, 32'h0000_04F8, 0, 8'h00));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h0000_0500, 1, 32'h0000_04FC, 0, 8'h00));
    tbl.push_back(v(0, 0, 32'h0,        1, 0, 1, 32'h0000_0504, 0, 32'h0000_0500, 0, 8'h00));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h0000_0504, 0, 32'h0000_0500, 0, 8'h82));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 1, 32'h0000_0504, 0, 32'h0,        1, 8'h00));
    tbl.push_back(v(0, 1, 32'hFFFF_FFF8, 0, 0, 1, 32'h0000_0504, 0, 32'h0,       1, 8'h00));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_out("reset", 32'h0000_0400, 1'b0, 32'h0, 1'b1, 8'h00, 1'b0);
    chk("reset pc_out", pc_out, 32'h0);
    next_cyc();
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      halt   = tbl[i].hlt;
      clk_en = tbl[i].cen;
      drive(tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].tlb);
      chk_out($sformatf("v%0d", i), tbl[i].e_addr, tbl[i].e_re, tbl[i].e_pc,
              tbl[i].e_bub, tbl[i].e_exc, 1'b0);
      next_cyc();
    end
    halt   = 1'b0;
    clk_en = 1'b1;

    // Streaming with random stalls across the 32-bit wrap.
    exp_next   = 32'hFFFF_FFF8;
    prev_issue = 1'b0;
    have_last  = 1'b0;
    last_pc    = '0;
    for (int c = 0; c < 40; c++) begin
      s = ($urandom_range(0, 3) == 0);
      drive(s, 1'b0, 32'h0, 1'b0);
      chk($sformatf("s%0d mem_addr", c), mem_addr, exp_next);
      chk($sformatf("s%0d mem_re", c), {31'd0, mem_re}, {31'd0, !s});
      if (prev_issue) begin
        got = sb.pop_front();
        chk($sformatf("s%0d pc_out", c), pc_out, got);
        chk($sformatf("s%0d bubble", c), {31'd0, bubble_out}, 32'd0);
        last_pc   = got;
        have_last = 1'b1;
      end else if (have_last) begin
        chk($sformatf("s%0d held pc_out", c), pc_out, last_pc);
      end
      if (!s) begin
        sb.push_back(exp_next);
        exp_next = exp_next + 32'd4;
      end
      prev_issue = !s;
      next_cyc();
    end

    // Asynchronous reset in the middle of a cycle.
    stall = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("midreset", 32'h0000_0400, 1'b0, 32'h0, 1'b1, 8'h00, 1'b0);
    chk("midreset pc_out", pc_out, 32'h0);
    next_cyc();
    rst_n = 1'b1;

    // BOOT cycle, carrying a taken update 0x600 -> 0x800.
    btb_upd        = 1'b1;
    btb_upd_pc     = 32'h0000_0600;
    btb_upd_target = 32'h0000_0800;
    btb_upd_taken  = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk_out("boot", 32'h0000_0400, 1'b0, 32'h0, 1'b1, 8'h00, 1'b0);
    next_cyc();
    btb_upd = 1'b0;
    drive(1'b0, 1'b1, 32'h0000_05FC, 1'b0);
    chk_out("b_redir", 32'h0000_0400, 1'b0, 32'h0, 1'b1, 8'h00, 1'b0);
    next_cyc();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk_out("b_5fc", 32'h0000_05FC, 1'b1, 32'h0, 1'b1, 8'h00, 1'b0);
    next_cyc();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk_out("b_600", 32'h0000_0600, 1'b1, 32'h0000_05FC, 1'b0, 8'h00, 1'b0);
    next_cyc();
    btb_upd       = 1'b1;
    btb_upd_taken = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk_out("b_pred", BTB ? 32'h0000_0800 : 32'h0000_0604, 1'b1, 32'h0000_0600,
            1'b0, 8'h00, BTB);
    next_cyc();
    btb_upd = 1'b0;
    drive(1'b0, 1'b1, 32'h0000_0600, 1'b0);
    chk_out("b_after", BTB ? 32'h0000_0804 : 32'h0000_0608, 1'b0,
            BTB ? 32'h0000_0800 : 32'h0000_0604, 1'b0, 8'h00, 1'b0);
    next_cyc();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk_out("b_re600", 32'h0000_0600, 1'b1, 32'h0, 1'b1, 8'h00, 1'b0);
    next_cyc();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk_out("b_cleared", 32'h0000_0604, 1'b1, 32'h0000_0600, 1'b0, 8'h00, 1'b0);
    next_cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
